padded_pixel_streamer: RTL and testbench
========================================

Name: padded_pixel_streamer

Overview:
Frame source that feeds the 3x3 line buffer. On `start` it reads an IMG_W x IMG_H 8-bit image from a synchronous ROM/RAM. It emits the padded raster stream the line buffer expects: TOTAL_W x TOTAL_H beats, row-major, starting at padded column 0, with zero bytes at every padding position. It sits between the image memory and the line buffer/conv window datapath.

Parameters:
IMG_W, 28, image width in pixels
IMG_H, 28, image height in pixels
PADDING, 1, zero border width on each side (0 allowed)
ADDR_W, $clog2(IMG_W*IMG_H), memory address width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle frame request; sampled only in IDLE
busy  out  1  high from the cycle after accepted start until done
done  out  1  one-cycle pulse after the last beat is accepted
mem_rd_en  out  1  memory read strobe
mem_addr  out  ADDR_W  memory address, row-major, addr = r*IMG_W + c
mem_rd_data  in  8  memory data, valid 1 cycle after mem_rd_en; held while mem_rd_en=0
out_data  out  8  stream pixel; 0 on padding beats
out_valid  out  1  stream beat valid (drives line buffer in_valid)
out_ready  in  1  downstream accept; tie 1 for the line buffer

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Derived constants: TOTAL_W = IMG_W + 2*PADDING; TOTAL_H = IMG_H + 2*PADDING; BEATS = TOTAL_W*TOTAL_H.
- Reset values:
  - FSM = IDLE.
  - busy, done, out_valid and mem_rd_en = 0.
  - mem_addr = 0.
  - Counters = 0.
- FSM states:
  - IDLE: start=1 -> STREAM, with row_cnt=0, col_cnt=0, addr=0.
  - STREAM: issues beats. After the beat at (TOTAL_H-1, TOTAL_W-1) is issued -> DRAIN.
  - DRAIN: waits until the final beat is accepted (out_valid && out_ready) -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- Pipeline:
  - Two stages: issue and output.
  - advance = !out_valid || out_ready.
  - In STREAM, when advance=1, the issue stage consumes (row_cnt, col_cnt). It sets pad_q = (row or col outside [PADDING, PADDING+IMG_dim-1]) and out_valid <= 1.
  - For non-pad positions it also asserts mem_rd_en with mem_addr = addr.
  - out_data = pad_q ? 0 : mem_rd_data (combinational mux after registered flag).
  - Latency: 1 cycle from issue to out_valid.
- Stall:
  - advance=0 freezes counters, pad_q and out_valid, with mem_rd_en=0.
  - The memory-hold guarantee keeps out_data stable during the stall.
- Address generation:
  - Incremental only, no multiplier.
  - addr increments by 1 after each non-pad issue.
  - Rows are contiguous, so no per-row jump is needed.
- Counter wrap:
  - col_cnt wraps TOTAL_W-1 -> 0 and increments row_cnt.
  - row_cnt at TOTAL_H-1 with col wrap ends issuing.
- out_valid drops the cycle after the final beat is accepted if no new beat is issued.
- Exactly BEATS beats per frame; never more, never fewer. The line buffer column counter depends on this.
- Edge cases:
  - start while busy: ignored.
  - start in the DONE cycle: ignored.
  - Back-to-back frames: start may be accepted in the cycle after done.
  - rst mid-frame: immediate return to IDLE with out_valid=0. The partial frame is abandoned and downstream must also be reset.
  - PADDING=0: no zero beats; BEATS = IMG_W*IMG_H.

Optional Feature:
STREAMER_LAST_EN:
- Defined: adds output port out_last (1 bit), registered with out_valid. It is high only on beat BEATS-1 and held stable during stall.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package `cnn_stream_pkg`:
  - PIXEL_W=8
  - IMG_W/IMG_H/PADDING defaults
  - TOTAL_W/TOTAL_H/BEATS localparam functions
  - state enum {IDLE, STREAM, DRAIN, DONE}
- One natural sub-module, `raster_counter`: row/col counters with wrap, an is_pad flag and a last flag, parameterised by TOTAL_W/TOTAL_H/PADDING.
- Address counter and FSM stay in the top.

Test Plan:
1. Defaults, out_ready=1, mem[i]=i[7:0], pulse start:
   - first out_valid 2 cycles after start edge.
   - exactly 900 beats.
   - beats 0..30 = 0, beat 31 = mem[0], beat 868 = mem[783]=0x0F, beats 869..899 = 0.
   - done pulses once.
2. IMG_W=4, IMG_H=3, PADDING=1, mem[i]=0x10+i:
   - 30 beats.
   - row 1 = 0,10,11,12,13,0; row 3 = 0,18,19,1A,1B,0; rows 0 and 4 all 0.
3. Random out_ready (50%):
   - sequence identical to scenario 1.
   - out_data/out_valid stable while out_valid && !out_ready.
   - mem_rd_en never high during stall.
4. start held high for 5 cycles, then re-pulsed mid-frame:
   - only one frame (900 beats).
   - second start ignored; busy continuous.
5. Assert rst at beat 400:
   - out_valid, busy, mem_rd_en = 0 asynchronously.
   - new start after release yields a full correct 900-beat frame.
6. STREAMER_LAST_EN defined, PADDING=0, 4x3:
   - 12 beats equal to mem[0..11].
   - out_last high only on beat 11.
   - done the cycle after its acceptance.

Source files
------------

// File: rtl/cnn_stream_pkg.sv
// Shared types and frame geometry helpers for the CNN pixel-stream blocks.
// Latency: n/a (package only).
// Backpressure: n/a.
package cnn_stream_pkg;

    localparam int PIXEL_W     = 8;
    localparam int IMG_W_DEF   = 28;
    localparam int IMG_H_DEF   = 28;
    localparam int PADDING_DEF = 1;

    // Padded extent of one image dimension.
    function automatic int total_dim(input int img, input int pad);
        return img + 2 * pad;
    endfunction

    // Number of stream beats in one padded frame.
    function automatic int frame_beats(input int img_w, input int img_h, input int pad);
        return total_dim(img_w, pad) * total_dim(img_h, pad);
    endfunction

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/padded_pixel_streamer_if.sv
// Memory read port plus pixel stream bundle of the padded pixel streamer.
// Latency: n/a (wires only).
// Backpressure: out_ready from the stream sink; mem_rd_data must hold while mem_rd_en=0.
// Ports: master = streamer side (drives mem_rd_en/mem_addr/out_*), slave = memory + sink side.
// Optional: STREAMER_LAST_EN adds out_last.
interface padded_pixel_streamer_if #(
    parameter int ADDR_W = 10
);
    import cnn_stream_pkg::*;

    logic                mem_rd_en;
    logic [ADDR_W-1:0]   mem_addr;
    logic [PIXEL_W-1:0]  mem_rd_data;
    logic [PIXEL_W-1:0]  out_data;
    logic                out_valid;
    logic                out_ready;
`ifdef STREAMER_LAST_EN
    logic                out_last;

    modport master (
        output mem_rd_en, mem_addr, out_data, out_valid, out_last,
        input  mem_rd_data, out_ready
    );
    modport slave (
        input  mem_rd_en, mem_addr, out_data, out_valid, out_last,
        output mem_rd_data, out_ready
    );
`else
    modport master (
        output mem_rd_en, mem_addr, out_data, out_valid,
        input  mem_rd_data, out_ready
    );
    modport slave (
        input  mem_rd_en, mem_addr, out_data, out_valid,
        output mem_rd_data, out_ready
    );
`endif

endinterface

// File: rtl/raster_counter.sv
// Row/column raster counter over the padded frame, with pad and last-position flags.
// Latency: flags are combinational from the current count; counts move on the step edge.
// Backpressure: counts hold whenever step=0.
// Ports: clear (restart at 0,0), step (advance one position), is_pad, last.
module raster_counter #(
    parameter int TOTAL_W = 30,
    parameter int TOTAL_H = 30,
    parameter int PADDING = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic step,
    output logic is_pad,
    output logic last
);
    localparam int IMG_W = TOTAL_W - 2 * PADDING;
    localparam int IMG_H = TOTAL_H - 2 * PADDING;
    localparam int CW    = (TOTAL_W > 1) ? $clog2(TOTAL_W) : 1;
    localparam int RW    = (TOTAL_H > 1) ? $clog2(TOTAL_H) : 1;
    localparam logic [CW-1:0] COL_MAX = CW'(TOTAL_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(TOTAL_H - 1);

    logic [CW-1:0] col;
    logic [RW-1:0] row;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (clear) begin
            col <= '0;
            row <= '0;
        end else if (step) begin
            if (col == COL_MAX) begin
                col <= '0;
                row <= (row == ROW_MAX) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Signed compares keep PADDING=0 free of always-false unsigned checks.
    always_comb begin
        is_pad = (int'(row) < PADDING) || (int'(row) >= PADDING + IMG_H) ||
                 (int'(col) < PADDING) || (int'(col) >= PADDING + IMG_W);
        last   = (row == ROW_MAX) && (col == COL_MAX);
    end

endmodule

// File: rtl/padded_pixel_streamer.sv
// Reads an IMG_W x IMG_H image from sync memory and streams it zero-padded, row-major.
// Latency: first out_valid 2 cycles after the start edge (issue stage, then output stage).
// Backpressure: !out_ready with out_valid freezes both stages and suppresses mem reads.
// Ports: clk, rst, start/busy/done control, bus = memory read port + pixel stream.
// Optional: STREAMER_LAST_EN adds out_last, high on the final beat of the frame.
module padded_pixel_streamer
    import cnn_stream_pkg::*;
#(
    parameter int IMG_W   = IMG_W_DEF,
    parameter int IMG_H   = IMG_H_DEF,
    parameter int PADDING = PADDING_DEF,
    parameter int ADDR_W  = $clog2(IMG_W * IMG_H)
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic done,
    padded_pixel_streamer_if.master bus
);
    localparam int TOTAL_W = total_dim(IMG_W, PADDING);
    localparam int TOTAL_H = total_dim(IMG_H, PADDING);

    state_t            state;
    logic              advance;
    logic              rc_pad;
    logic              rc_last;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              issue_vld;
    logic              issue_pad;
    logic              pad_q;
    logic              out_valid_q;
`ifdef STREAMER_LAST_EN
    logic              issue_last;
    logic              out_last_q;
`endif

    assign advance = !out_valid_q || bus.out_ready;

    raster_counter #(
        .TOTAL_W (TOTAL_W),
        .TOTAL_H (TOTAL_H),
        .PADDING (PADDING)
    ) u_raster (
        .clk    (clk),
        .rst    (rst),
        .clear  ((state == IDLE) && start),
        .step   ((state == STREAM) && advance),
        .is_pad (rc_pad),
        .last   (rc_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            addr        <= '0;
            mem_addr_q  <= '0;
            issue_vld   <= 1'b0;
            issue_pad   <= 1'b0;
            pad_q       <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef STREAMER_LAST_EN
            issue_last  <= 1'b0;
            out_last_q  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            // Output stage takes whatever the issue stage holds; the issue stage
            // empties unless STREAM refills it below.
            if (advance) begin
                out_valid_q <= issue_vld;
                pad_q       <= issue_pad;
                issue_vld   <= 1'b0;
                issue_pad   <= 1'b0;
`ifdef STREAMER_LAST_EN
                out_last_q  <= issue_last;
                issue_last  <= 1'b0;
`endif
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= STREAM;
                        busy  <= 1'b1;
                        addr  <= '0;
                    end
                end
                STREAM: begin
                    if (advance) begin
                        issue_vld  <= 1'b1;
                        issue_pad  <= rc_pad;
                        mem_addr_q <= addr;
`ifdef STREAMER_LAST_EN
                        issue_last <= rc_last;
`endif
                        // Image rows are contiguous in memory, so a plain
                        // increment on real pixels walks the whole image.
                        if (!rc_pad) begin
                            addr <= addr + 1'b1;
                        end
                        if (rc_last) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Empty issue stage means the beat being accepted is the last one.
                    if (out_valid_q && bus.out_ready && !issue_vld) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // The read fires on the same edge the output stage loads, so the returned
    // byte lines up with its beat and the memory hold covers any stall.
    assign bus.mem_rd_en = issue_vld && !issue_pad && advance;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = pad_q ? '0 : bus.mem_rd_data;
`ifdef STREAMER_LAST_EN
    assign bus.out_last  = out_last_q;
`endif

endmodule

// File: tb/tb_padded_pixel_streamer.sv
module tb_padded_pixel_streamer;
    import cnn_stream_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] start = 3'b000;
    logic       ready = 1'b1;
    bit         rand_ready = 1'b0;
    logic [2:0] busy;
    logic [2:0] done;

    always #5 clk = ~clk;

    // a: 28x28 pad 1, mem[i]=i ; b: 4x3 pad 1, mem[i]=0x10+i ; c: 4x3 pad 0, mem[i]=0xA0+i
    padded_pixel_streamer_if #(.ADDR_W(10)) if_a ();
    padded_pixel_streamer_if #(.ADDR_W(4))  if_b ();
    padded_pixel_streamer_if #(.ADDR_W(4))  if_c ();

    padded_pixel_streamer u_a (
        .clk(clk), .rst(rst), .start(start[0]), .busy(busy[0]), .done(done[0]), .bus(if_a.master)
    );
    padded_pixel_streamer #(.IMG_W(4), .IMG_H(3), .PADDING(1), .ADDR_W(4)) u_b (
        .clk(clk), .rst(rst), .start(start[1]), .busy(busy[1]), .done(done[1]), .bus(if_b.master)
    );
    padded_pixel_streamer #(.IMG_W(4), .IMG_H(3), .PADDING(0), .ADDR_W(4)) u_c (
        .clk(clk), .rst(rst), .start(start[2]), .busy(busy[2]), .done(done[2]), .bus(if_c.master)
    );

    assign if_a.out_ready = ready;
    assign if_b.out_ready = ready;
    assign if_c.out_ready = ready;

    // Synchronous memories: data one cycle after the read strobe, held otherwise.
    always @(posedge clk) if (if_a.mem_rd_en) if_a.mem_rd_data <= 8'(if_a.mem_addr);
    always @(posedge clk) if (if_b.mem_rd_en) if_b.mem_rd_data <= 8'h10 + 8'(if_b.mem_addr);
    always @(posedge clk) if (if_c.mem_rd_en) if_c.mem_rd_data <= 8'hA0 + 8'(if_c.mem_addr);

    logic [2:0] vld, rden;
    logic [7:0] dat [3];
    assign vld  = {if_c.out_valid, if_b.out_valid, if_a.out_valid};
    assign rden = {if_c.mem_rd_en, if_b.mem_rd_en, if_a.mem_rd_en};
    assign dat[0] = if_a.out_data;
    assign dat[1] = if_b.out_data;
    assign dat[2] = if_c.out_data;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: padded raster computed straight from geometry.
    logic [7:0] exp_q [$];
    task automatic build_exp(input int w, input int h, input int p, input int base);
        exp_q.delete();
        for (int r = 0; r < h + 2 * p; r++) begin
            for (int c = 0; c < w + 2 * p; c++) begin
                if (r < p || r >= p + h || c < p || c >= p + w)
                    exp_q.push_back(8'h00);
                else
                    exp_q.push_back(8'(base + (r - p) * w + (c - p)));
            end
        end
    endtask

    // Monitor: captures accepted beats of the selected DUT, checks stall rules on all.
    int         sel = 0;
    int         cyc = 0;
    int         last_acc_cyc = 0;
    int         done_cyc = 0;
    int         done_cnt [3] = '{0, 0, 0};
    logic [7:0] cap_q [$];
    bit         lastf_q [$];
    logic [2:0] prev_stall = 3'b000;
    logic [7:0] prev_dat [3];
`ifdef STREAMER_LAST_EN
    logic       lst_c;
    assign lst_c = if_c.out_last;
`endif

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_stall = 3'b000;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (prev_stall[k]) begin
                    chk("stall_valid_held", 32'(vld[k]), 32'd1);
                    chk("stall_data_held", 32'(dat[k]), 32'(prev_dat[k]));
                end
                if (vld[k] && !ready) chk("stall_no_mem_read", 32'(rden[k]), 32'd0);
                prev_stall[k] = vld[k] && !ready;
                prev_dat[k]   = dat[k];
                if (done[k]) begin
                    done_cnt[k]++;
                    if (k == sel) done_cyc = cyc;
                end
                if (vld[k] && ready && k == sel) begin
                    cap_q.push_back(dat[k]);
                    last_acc_cyc = cyc;
`ifdef STREAMER_LAST_EN
                    if (k == 2) lastf_q.push_back(lst_c);
`endif
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic start_pulse(input int k, input int len);
        @(posedge clk);
        #1 start[k] = 1'b1;
        repeat (len) @(posedge clk);
        #1 start[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input int budget, input string tag);
        int n   = 0;
        int gap = 0;
        bit ok  = 1'b0;
        while (n < budget) begin
            @(negedge clk);
            n++;
            if (done[k]) begin
                ok = 1'b1;
                break;
            end
            if (!busy[k]) gap++;
        end
        #1;
        chk({tag, "_done_seen"}, 32'(ok), 32'd1);
        chk({tag, "_busy_gap"}, gap, 0);
    endtask

    task automatic cmp_frame(input string tag);
        chk({tag, "_beats"}, cap_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
            chk({tag, "_beat"}, 32'(cap_q[i]), 32'(exp_q[i]));
        chk({tag, "_done_timing"}, done_cyc, last_acc_cyc + 1);
    endtask

    task automatic settle_check(input int k, input int d0, input string tag);
        repeat (5) @(negedge clk);
        #1;
        chk({tag, "_done_once"}, done_cnt[k] - d0, 1);
        chk({tag, "_idle_busy"}, 32'(busy[k]), 32'd0);
        chk({tag, "_idle_valid"}, 32'(vld[k]), 32'd0);
    endtask

    initial begin
        int d0;
        int n;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy[0]), 32'd0);
        chk("rst_done", 32'(done[0]), 32'd0);
        chk("rst_valid", 32'(vld[0]), 32'd0);
        chk("rst_rd_en", 32'(rden[0]), 32'd0);
        chk("rst_addr", 32'(if_a.mem_addr), 32'd0);
        @(negedge clk) rst = 1'b0;

        // 1: default geometry, always ready, first-beat latency
        sel = 0; cap_q.delete(); build_exp(28, 28, 1, 0); d0 = done_cnt[0];
        @(posedge clk);
        #1 start[0] = 1'b1;
        @(posedge clk);
        #1 start[0] = 1'b0;
        chk("s1_busy_after_start", 32'(busy[0]), 32'd1);
        chk("s1_valid_cycle0", 32'(vld[0]), 32'd0);
        @(posedge clk);
        #1 chk("s1_valid_cycle1", 32'(vld[0]), 32'd0);
        @(posedge clk);
        #1 chk("s1_valid_cycle2", 32'(vld[0]), 32'd1);
        wait_done(0, 3000, "s1");
        cmp_frame("s1");
        if (cap_q.size() == 900) begin
            chk("s1_beat31", 32'(cap_q[31]), 32'h00);
            chk("s1_beat868", 32'(cap_q[868]), 32'h0F);
        end
        settle_check(0, d0, "s1");

        // 3: random backpressure
        sel = 0; cap_q.delete(); d0 = done_cnt[0];
        rand_ready = 1'b1;
        start_pulse(0, 1);
        wait_done(0, 6000, "s3");
        rand_ready = 1'b0;
        cmp_frame("s3");
        settle_check(0, d0, "s3");

        // 4: long start, then a mid-frame re-pulse
        sel = 0; cap_q.delete(); d0 = done_cnt[0];
        start_pulse(0, 5);
        repeat (300) @(posedge clk);
        #1 start[0] = 1'b1;
        chk("s4_busy_mid", 32'(busy[0]), 32'd1);
        @(posedge clk);
        #1 start[0] = 1'b0;
        wait_done(0, 3000, "s4");
        cmp_frame("s4");
        settle_check(0, d0, "s4");
        repeat (10) @(negedge clk);
        chk("s4_no_second_frame", cap_q.size(), 900);

        // 5: reset at beat 400, then a clean frame
        sel = 0; cap_q.delete();
        start_pulse(0, 1);
        n = 0;
        while (cap_q.size() < 400 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("s5_reached_400", 32'(cap_q.size() >= 400), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("s5_async_valid", 32'(vld[0]), 32'd0);
        chk("s5_async_busy", 32'(busy[0]), 32'd0);
        chk("s5_async_rd_en", 32'(rden[0]), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cap_q.delete(); d0 = done_cnt[0];
        start_pulse(0, 1);
        wait_done(0, 3000, "s5");
        cmp_frame("s5");
        settle_check(0, d0, "s5");

        // 2: 4x3 pad 1, plus a start landing in the DONE cycle
        sel = 1; cap_q.delete(); build_exp(4, 3, 1, 'h10); d0 = done_cnt[1];
        start_pulse(1, 1);
        wait_done(1, 500, "s2");
        start[1] = 1'b1;
        @(posedge clk);
        #1 start[1] = 1'b0;
        cmp_frame("s2");
        if (cap_q.size() == 30) begin
            chk("s2_row1_col1", 32'(cap_q[7]), 32'h10);
            chk("s2_row3_col4", 32'(cap_q[22]), 32'h1B);
        end
        settle_check(1, d0, "s2");
        chk("s2_done_cycle_start_ignored", cap_q.size(), 30);

        // 6: 4x3 pad 0, back-to-back frames
        sel = 2; cap_q.delete(); lastf_q.delete(); build_exp(4, 3, 0, 'hA0);
        start_pulse(2, 1);
        wait_done(2, 500, "s6a");
        cmp_frame("s6a");
`ifdef STREAMER_LAST_EN
        chk("s6_last_count", lastf_q.size(), 12);
        for (int i = 0; i < lastf_q.size(); i++)
            chk("s6_last_flag", 32'(lastf_q[i]), 32'(i == 11));
`endif
        cap_q.delete(); lastf_q.delete(); d0 = done_cnt[2];
        @(posedge clk);
        #1 start[2] = 1'b1;
        @(posedge clk);
        #1 start[2] = 1'b0;
        chk("s6_back_to_back_busy", 32'(busy[2]), 32'd1);
        wait_done(2, 500, "s6b");
        cmp_frame("s6b");
        settle_check(2, d0, "s6b");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule
